ks_control_unit: RTL

Multi-cycle control FSM for the K&S processor. It consumes the decoded instruction from the decode stage and the registered ALU flags from the datapath. It drives every datapath and memory enable needed to fetch, execute and retire one instruction at a time. It also keeps a retired-instruction counter for debug and coverage.

---
 rtl/ks_control_unit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ks_control_unit.sv
// Multi-cycle control FSM for the K&S processor: sequences fetch/decode/execute
// for one instruction at a time and counts retired instructions.
module ks_control_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       decoded_instruction,
  input  logic             zero_op,
  input  logic             neg_op,
  input  logic             overflow_op,
  output logic             ir_enable,
  output logic             pc_enable,
  output logic             branch,
  output logic             addr_sel,
  output logic             c_sel,
  output logic [1:0]       operation,
  output logic             write_reg_enable,
  output logic             flags_reg_enable,
  output logic             ram_write_enable,
  output logic             halt,
  output logic [CNT_W-1:0] retired_count
);

  localparam logic [4:0] I_NOP    = 5'b00000;
  localparam logic [4:0] I_LOAD   = 5'b00001;
  localparam logic [4:0] I_STORE  = 5'b00010;
  localparam logic [4:0] I_MOVE   = 5'b00011;
  localparam logic [4:0] I_ADD    = 5'b00100;
  localparam logic [4:0] I_SUB    = 5'b00101;
  localparam logic [4:0] I_AND    = 5'b00110;
  localparam logic [4:0] I_OR     = 5'b00111;
  localparam logic [4:0] I_BRANCH = 5'b01000;
  localparam logic [4:0] I_BZERO  = 5'b01001;
  localparam logic [4:0] I_BNZERO = 5'b01010;
  localparam logic [4:0] I_BNEG   = 5'b01011;
  localparam logic [4:0] I_BNNEG  = 5'b01100;
  localparam logic [4:0] I_BOV    = 5'b01101;
  localparam logic [4:0] I_BNOV   = 5'b01110;
  localparam logic [4:0] I_HALT   = 5'b11111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_LOAD_ADDR, S_LOAD_WB, S_STORE,
    S_MOVE, S_ALU, S_BR, S_HALT
  } state_t;

  state_t     state, state_nxt;
  logic       retire;
  logic       take;
  logic       ir_c, pc_c, br_c, as_c, cs_c, wr_c, fl_c, ram_c, halt_c;
  logic [1:0] op_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_FETCH;
      retired_count <= '0;
    end else begin
      state <= state_nxt;
      if (retire) retired_count <= retired_count + CNT_W'(1);
    end
  end

  always_comb begin
    take = 1'b0;
    case (decoded_instruction)
      I_BRANCH: take = 1'b1;
      I_BZERO:  take = zero_op;
      I_BNZERO: take = !zero_op;
      I_BNEG:   take = neg_op;
      I_BNNEG:  take = !neg_op;
      I_BOV:    take = overflow_op;
      I_BNOV:   take = !overflow_op;
      default:  take = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    ir_c = 1'b0; pc_c = 1'b0; br_c = 1'b0; as_c = 1'b0; cs_c = 1'b0;
    wr_c = 1'b0; fl_c = 1'b0; ram_c = 1'b0; halt_c = 1'b0;
    op_c = 2'b00;
    case (state)
      S_FETCH: begin
        ir_c      = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        pc_c = 1'b1;
        case (decoded_instruction)
          I_LOAD:                     state_nxt = S_LOAD_ADDR;
          I_STORE:                    state_nxt = S_STORE;
          I_MOVE:                     state_nxt = S_MOVE;
          I_ADD, I_SUB, I_AND, I_OR:  state_nxt = S_ALU;
          I_BRANCH, I_BZERO, I_BNZERO, I_BNEG,
          I_BNNEG, I_BOV, I_BNOV:     state_nxt = S_BR;
          I_HALT: begin
            state_nxt = S_HALT;
            retire    = 1'b1;
          end
          default: begin
            // NOP and unassigned codes retire straight back to fetch
            state_nxt = S_FETCH;
            retire    = 1'b1;
          end
        endcase
      end
      S_LOAD_ADDR: begin
        as_c      = 1'b1;
        state_nxt = S_LOAD_WB;
      end
      S_LOAD_WB: begin
        as_c = 1'b1; cs_c = 1'b1; wr_c = 1'b1;
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      S_STORE: begin
        as_c = 1'b1; ram_c = 1'b1;
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      S_MOVE: begin
        // source is passed through OR with itself; flags left untouched
        op_c = 2'b11; wr_c = 1'b1;
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      S_ALU: begin
        case (decoded_instruction)
          I_SUB:   op_c = 2'b01;
          I_AND:   op_c = 2'b10;
          I_OR:    op_c = 2'b11;
          default: op_c = 2'b00;
        endcase
        wr_c = 1'b1; fl_c = 1'b1;
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      S_BR: begin
        br_c = take; pc_c = take;
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      S_HALT: begin
        halt_c    = 1'b1;
        state_nxt = S_HALT;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Gate with rst_n so no enable survives the falling edge of reset mid-cycle
  assign ir_enable        = rst_n & ir_c;
  assign pc_enable        = rst_n & pc_c;
  assign branch           = rst_n & br_c;
  assign addr_sel         = rst_n & as_c;
  assign c_sel            = rst_n & cs_c;
  assign operation        = {2{rst_n}} & op_c;
  assign write_reg_enable = rst_n & wr_c;
  assign flags_reg_enable = rst_n & fl_c;
  assign ram_write_enable = rst_n & ram_c;
  assign halt             = rst_n & halt_c;

endmodule
